// File: rtl/run_detector_if.sv
// run_detector_if: sample inputs and detector observation outputs of run_detector
interface run_detector_if #(
  parameter int CNT_W = 4,
  parameter int EVT_W = 8
);
  logic en;
  logic clear;
  logic polarity;
  logic x;
  logic [CNT_W-1:0] run_count;
  logic y;
  logic y_pulse;
  logic [EVT_W-1:0] events;
  modport master (output en, clear, polarity, x, input run_count, y, y_pulse, events);
  modport slave (input en, clear, polarity, x, output run_count, y, y_pulse, events);
endinterface

// File: rtl/run_detector.sv
// run_detector: Moore run-length detector with saturating run counter, entry strobe and event counter.
// Define RUN_DETECTOR_EVTCNT_EN to build the events counter; otherwise events is tied to 0.
module run_detector #(
  parameter int RUN_LEN = 2,
  parameter int CNT_W = 4,
  parameter int EVT_W = 8
) (
  input logic clock,
  input logic reset,
  run_detector_if.slave bus
);
  localparam logic [CNT_W-1:0] SAT = '1;
  localparam logic [CNT_W-1:0] LEN = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] PRE = CNT_W'(RUN_LEN - 1);
  logic [CNT_W-1:0] cnt;
  logic pulse;
  logic hit;
  logic entry;
  assign hit = bus.x == bus.polarity;
  // the count only ever passes RUN_LEN-1 once per run, so saturation cannot retrigger an entry
  assign entry = bus.en && !bus.clear && hit && cnt == PRE;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      cnt <= '0;
      pulse <= 1'b0;
    end else if (bus.clear) begin
      cnt <= '0;
      pulse <= 1'b0;
    end else if (!bus.en) begin
      pulse <= 1'b0;
    end else begin
      cnt <= !hit ? '0 : cnt == SAT ? cnt : cnt + 1'b1;
      pulse <= entry;
    end
`ifdef RUN_DETECTOR_EVTCNT_EN
  logic [EVT_W-1:0] evt;
  always_ff @(posedge clock or negedge reset)
    if (!reset) evt <= '0;
    else if (bus.clear) evt <= '0;
    else if (entry) evt <= evt + 1'b1;
  assign bus.events = evt;
`else
  assign bus.events = '0;
`endif
  assign bus.run_count = cnt;
  assign bus.y = cnt >= LEN;
  assign bus.y_pulse = pulse;
endmodule

// File: tb/tb_run_detector.sv
// tb_run_detector: three detector configurations against an unbounded-run-length reference model.
module tb_run_detector;
`ifdef RUN_DETECTOR_EVTCNT_EN
  localparam bit EVT = 1'b1;
`else
  localparam bit EVT = 1'b0;
`endif
  localparam int RL [3] = '{2, 3, 1};
  localparam int CW [3] = '{4, 2, 4};
  localparam int EW [3] = '{8, 8, 2};
  logic clock = 1'b0;
  logic reset;
  logic en, clear, polarity, x;
  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;
  int run [3];
  int ev [3];
  bit pul [3];
  always #5 clock = ~clock;
  run_detector_if #(.CNT_W(4), .EVT_W(8)) ia ();
  run_detector_if #(.CNT_W(2), .EVT_W(8)) ib ();
  run_detector_if #(.CNT_W(4), .EVT_W(2)) ic ();
  assign {ia.en, ia.clear, ia.polarity, ia.x} = {en, clear, polarity, x};
  assign {ib.en, ib.clear, ib.polarity, ib.x} = {en, clear, polarity, x};
  assign {ic.en, ic.clear, ic.polarity, ic.x} = {en, clear, polarity, x};
  run_detector #(.RUN_LEN(2), .CNT_W(4), .EVT_W(8)) dut_a (.clock(clock), .reset(reset), .bus(ia));
  run_detector #(.RUN_LEN(3), .CNT_W(2), .EVT_W(8)) dut_b (.clock(clock), .reset(reset), .bus(ib));
  run_detector #(.RUN_LEN(1), .CNT_W(4), .EVT_W(2)) dut_c (.clock(clock), .reset(reset), .bus(ic));

  // model: run is the true unbounded length of the current matching run
  always @(posedge clock or negedge reset)
    for (int i = 0; i < 3; i++)
      if (!reset) begin
        run[i] <= 0;
        pul[i] <= 1'b0;
        ev[i] <= 0;
      end else if (clear) begin
        run[i] <= 0;
        pul[i] <= 1'b0;
        ev[i] <= 0;
      end else if (!en) begin
        pul[i] <= 1'b0;
      end else begin
        run[i] <= (x == polarity) ? run[i] + 1 : 0;
        pul[i] <= (x == polarity) && run[i] + 1 == RL[i];
        ev[i] <= ((x == polarity) && run[i] + 1 == RL[i]) ? (ev[i] + 1) % (1 << EW[i]) : ev[i];
      end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i, input logic [31:0] rc, input logic yv, input logic pv, input logic [31:0] evv);
    int sat;
    sat = (1 << CW[i]) - 1;
    check($sformatf("dut%0d.run_count", i), rc, run[i] > sat ? sat : run[i]);
    check($sformatf("dut%0d.y", i), {31'd0, yv}, {31'd0, run[i] >= RL[i]});
    check($sformatf("dut%0d.y_pulse", i), {31'd0, pv}, {31'd0, pul[i]});
    check($sformatf("dut%0d.events", i), evv, EVT ? ev[i] : 0);
  endtask

  always @(negedge clock)
    if (cmp_on) begin
      cmp_inst(0, 32'(ia.run_count), ia.y, ia.y_pulse, 32'(ia.events));
      cmp_inst(1, 32'(ib.run_count), ib.y, ib.y_pulse, 32'(ib.events));
      cmp_inst(2, 32'(ic.run_count), ic.y, ic.y_pulse, 32'(ic.events));
    end

  task automatic tick(input logic e, input logic c, input logic p, input logic xv);
    {en, clear, polarity, x} = {e, c, p, xv};
    @(negedge clock);
  endtask

  initial begin
    int sat_rc [6];
    int wrap [10];
    sat_rc = '{1, 2, 3, 3, 3, 3};
    wrap = '{1, 1, 2, 2, 3, 3, 0, 0, 1, 1};
    reset = 1'b0;
    {en, clear, polarity, x} = 4'b0;
    #3 reset = 1'b1;
    @(negedge clock);
    cmp_on = 1'b1;
    check("reset a.run_count", 32'(ia.run_count), 0);
    check("reset a.y", {31'd0, ia.y}, 0);
    tick(1, 0, 0, 0);
    check("zeros1 a.run_count", 32'(ia.run_count), 1);
    check("zeros1 a.y", {31'd0, ia.y}, 0);
    check("rl1 c.y_pulse", {31'd0, ic.y_pulse}, 1);
    tick(1, 0, 0, 0);
    check("zeros2 a.run_count", 32'(ia.run_count), 2);
    check("zeros2 a.y", {31'd0, ia.y}, 1);
    check("zeros2 a.y_pulse", {31'd0, ia.y_pulse}, 1);
    check("zeros2 a.events", 32'(ia.events), EVT ? 1 : 0);
    tick(1, 0, 0, 1);
    check("break a.run_count", 32'(ia.run_count), 0);
    check("break a.y", {31'd0, ia.y}, 0);
    check("break a.y_pulse", {31'd0, ia.y_pulse}, 0);
    tick(1, 1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      tick(1, 0, 0, 0);
      check("sat b.run_count", 32'(ib.run_count), sat_rc[k]);
      check("sat b.y", {31'd0, ib.y}, k >= 2 ? 1 : 0);
      check("sat b.y_pulse", {31'd0, ib.y_pulse}, k == 2 ? 1 : 0);
    end
    check("sat b.events", 32'(ib.events), EVT ? 1 : 0);
    tick(1, 1, 1, 0);
    tick(1, 0, 1, 1);
    tick(1, 0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      tick(0, 0, 1, 0);
      check("stall b.run_count", 32'(ib.run_count), 2);
      check("stall b.y", {31'd0, ib.y}, 0);
    end
    tick(1, 0, 1, 1);
    check("resume b.y", {31'd0, ib.y}, 1);
    check("resume b.y_pulse", {31'd0, ib.y_pulse}, 1);
    tick(0, 0, 1, 1);
    check("nostretch b.y_pulse", {31'd0, ib.y_pulse}, 0);
    check("nostretch b.y", {31'd0, ib.y}, 1);
    tick(1, 1, 1, 0);
    tick(1, 0, 1, 1);
    tick(1, 0, 1, 1);
    tick(1, 0, 1, 0);
    for (int k = 0; k < 5; k++) tick(1, 0, 1, 1);
    check("pre-clear a.run_count", 32'(ia.run_count), 5);
    check("pre-clear a.events", 32'(ia.events), EVT ? 2 : 0);
    tick(0, 1, 1, 1);
    check("clear a.run_count", 32'(ia.run_count), 0);
    check("clear a.y", {31'd0, ia.y}, 0);
    check("clear a.events", 32'(ia.events), 0);
    check("clear a.y_pulse", {31'd0, ia.y_pulse}, 0);
    for (int k = 0; k < 3; k++) tick(1, 0, 1, 1);
    check("pre-reset a.run_count", 32'(ia.run_count), 3);
    #2 reset = 1'b0;
    #1;
    check("async a.run_count", 32'(ia.run_count), 0);
    check("async a.y", {31'd0, ia.y}, 0);
    check("async a.events", 32'(ia.events), 0);
    @(negedge clock);
    reset = 1'b1;
    tick(1, 0, 1, 1);
    check("post-reset1 a.y", {31'd0, ia.y}, 0);
    tick(1, 0, 1, 1);
    check("post-reset2 a.y", {31'd0, ia.y}, 1);
    check("post-reset2 a.events", 32'(ia.events), EVT ? 1 : 0);
    tick(1, 1, 0, 1);
    for (int k = 0; k < 10; k++) begin
      tick(1, 0, 0, k[0]);
      check("wrap c.events", 32'(ic.events), EVT ? wrap[k] : 0);
    end
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) polarity = ~polarity;
      en = $urandom_range(0, 4) != 0;
      clear = $urandom_range(0, 60) == 0;
      x = ($urandom_range(0, 5) != 0) ? polarity : ~polarity;
      if ($urandom_range(0, 250) == 0) begin
        #2 reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
      end else begin
        @(negedge clock);
      end
    end
    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
